trap_ctrl: RTL

//  Machine-mode trap sequencer between writeback and the CSR file. Turns WB-stage

---
 rtl/trap_ctrl_pkg.sv | 19 +
 rtl/trap_timer.sv | 29 ++
 rtl/trap_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared cause codes and sequencer state encoding for the machine-mode trap controller.
package trap_ctrl_pkg;

    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_EBREAK  = 5'd3;
    localparam logic [4:0] CAUSE_ECALL_M = 5'd11;
    localparam logic [4:0] CAUSE_MTI     = 5'd7;
    localparam logic [4:0] CAUSE_MEI     = 5'd11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        TRAP_IDLE     = 2'd0,
        TRAP_COMMIT   = 2'd1,
        TRAP_REDIRECT = 2'd2,
        TRAP_HOLD     = 2'd3
    } trap_state_t;

endpackage

// File: rtl/trap_timer.sv
// Machine timer: free-running mtime, writable mtimecmp, level pending compare.
// Only instantiated when TRAP_TIMER_EN is defined.
module trap_timer #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wen,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] mtime,
    output logic            pending
);

    logic [XLEN-1:0] mtimecmp;

    always_ff @(posedge clock) begin
        if (reset) begin
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            mtime <= mtime + 1'b1;
            if (wen)
                mtimecmp <= wdata;
        end
    end

    assign pending = (mtime >= mtimecmp);

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: WB event -> CSR commit -> fetch redirect -> stall hold.
// Optional machine timer interrupt source enabled by defining TRAP_TIMER_EN.
//
// state         | meaning
// TRAP_IDLE     | sampling WB for trap/interrupt/mret
// TRAP_COMMIT   | one-cycle CSR commit strobe, pipeline flush
// TRAP_REDIRECT | one-cycle fetch redirect to vector or mepc
// TRAP_HOLD     | stall for FLUSH_CYCLES while the front end refills
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wb_valid_i,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic            wb_ecall_i,
    input  logic            wb_ebreak_i,
    input  logic            wb_illegal_i,
    input  logic            wb_mret_i,
    input  logic            mie_i,
    input  logic            ext_irq_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            exception_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] pc_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            stall_o
`ifdef TRAP_TIMER_EN
    ,
    input  logic            timecmp_wen_i,
    input  logic [XLEN-1:0] timecmp_wdata_i,
    output logic [XLEN-1:0] mtime_o
`endif
);

    trap_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             lat_irq, lat_mret;
    logic [4:0]       lat_code;
    logic [XLEN-1:0]  lat_pc;

    logic             timer_pending;
    logic             ev_take, ev_irq, ev_mret;
    logic [4:0]       ev_code;
    logic [XLEN-1:0]  lat_cause, tvec_base, trap_target;
    logic [1:0]       unused_bits;

`ifdef TRAP_TIMER_EN
    trap_timer #(.XLEN(XLEN)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .wen     (timecmp_wen_i),
        .wdata   (timecmp_wdata_i),
        .mtime   (mtime_o),
        .pending (timer_pending)
    );
`else
    assign timer_pending = 1'b0;
`endif

    assign unused_bits = mepc_i[1:0];

    // Priority: ext irq > timer irq > illegal > ebreak > ecall > mret
    always_comb begin
        ev_take = 1'b0;
        ev_irq  = 1'b0;
        ev_mret = 1'b0;
        ev_code = '0;
        if (wb_valid_i) begin
            if (mie_i && ext_irq_i) begin
                ev_take = 1'b1;
                ev_irq  = 1'b1;
                ev_code = CAUSE_MEI;
            end else if (mie_i && timer_pending) begin
                ev_take = 1'b1;
                ev_irq  = 1'b1;
                ev_code = CAUSE_MTI;
            end else if (wb_illegal_i) begin
                ev_take = 1'b1;
                ev_code = CAUSE_ILLEGAL;
            end else if (wb_ebreak_i) begin
                ev_take = 1'b1;
                ev_code = CAUSE_EBREAK;
            end else if (wb_ecall_i) begin
                ev_take = 1'b1;
                ev_code = CAUSE_ECALL_M;
            end else if (wb_mret_i) begin
                ev_take = 1'b1;
                ev_mret = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= TRAP_IDLE;
            cnt      <= '0;
            lat_irq  <= 1'b0;
            lat_mret <= 1'b0;
            lat_code <= '0;
            lat_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (state == TRAP_IDLE && ev_take) begin
                lat_irq  <= ev_irq;
                lat_mret <= ev_mret;
                lat_code <= ev_code;
                lat_pc   <= wb_pc_i;
            end
            if (state == TRAP_REDIRECT)
                cnt <= CNT_W'(FLUSH_CYCLES);
            else if (state == TRAP_HOLD)
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TRAP_IDLE:     if (ev_take) state_nxt = TRAP_COMMIT;
            TRAP_COMMIT:   state_nxt = TRAP_REDIRECT;
            TRAP_REDIRECT: state_nxt = TRAP_HOLD;
            TRAP_HOLD:     if (cnt == CNT_W'(1)) state_nxt = TRAP_IDLE;
            default:       state_nxt = TRAP_IDLE;
        endcase
    end

    assign lat_cause = {lat_irq, {(XLEN-6){1'b0}}, lat_code};
    assign tvec_base = {mtvec_i[XLEN-1:2], 2'b00};

    // Only mode 1 vectors, and only for interrupts; modes 2/3 fall back to direct
    always_comb begin
        trap_target = tvec_base;
        if (lat_mret)
            trap_target = {mepc_i[XLEN-1:2], 2'b00};
        else if (mtvec_i[1:0] == 2'b01 && lat_irq)
            trap_target = tvec_base + (XLEN'(lat_code) << 2);
    end

    always_comb begin
        exception_o      = 1'b0;
        mcause_o         = '0;
        pc_o             = '0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        stall_o          = 1'b0;
        case (state)
            TRAP_COMMIT: begin
                flush_o = 1'b1;
                stall_o = 1'b1;
                if (!lat_mret) begin
                    exception_o = 1'b1;
                    mcause_o    = lat_cause;
                    pc_o        = lat_pc;
                end
            end
            TRAP_REDIRECT: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = trap_target;
                flush_o          = 1'b1;
                stall_o          = 1'b1;
            end
            TRAP_HOLD: stall_o = 1'b1;
            default: ;
        endcase
    end

endmodule
